// File: rtl/scnn_act_compressor_pkg.sv
// Shared constants, types and the ReLU/saturation helper for the SCNN activation compressor.
// The compressed-activation reader on the next layer's input side relies on the same definitions.
package scnn_act_compressor_pkg;

  localparam int N_ELEMS = 64;
  localparam int IN_W    = 32;
  localparam int OUT_W   = 16;
  localparam int IDX_W   = $clog2(N_ELEMS);

  localparam logic signed [IN_W-1:0] SAT_MAX = IN_W'((1 << (OUT_W - 1)) - 1);
  localparam logic signed [IN_W-1:0] SAT_MIN = -SAT_MAX - 1;

  typedef enum logic [1:0] {IDLE, SCAN, EMIT, DONE} cmp_state_t;

  typedef struct packed {
    logic [OUT_W-1:0] value;
    logic [IDX_W-1:0] index;
  } act_pair_t;

  function automatic logic [OUT_W-1:0] sat_relu(input logic signed [IN_W-1:0] x,
                                                input logic                   relu_en);
    logic signed [IN_W-1:0] y;
    if (relu_en && x < 0) y = '0;
    else                  y = x;
    if (y > SAT_MAX)      return SAT_MAX[OUT_W-1:0];
    else if (y < SAT_MIN) return SAT_MIN[OUT_W-1:0];
    return y[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/scnn_act_compressor_if.sv
// Valid/ready stream carrying one (value, index) activation pair per beat plus an end-of-plane flag.
interface scnn_act_compressor_if;
  import scnn_act_compressor_pkg::*;

  logic      valid;
  logic      ready;
  act_pair_t pair;
  logic      last;

  modport master (output valid, output pair, output last, input ready);
  modport slave  (input valid, input pair, input last, output ready);

endinterface

// File: rtl/scnn_act_compressor_ffs.sv
// Combinational find-first-set over the plane mask: lowest set index, any-set and exactly-one flags.
module scnn_act_compressor_ffs
  import scnn_act_compressor_pkg::*;
(
  input  logic [N_ELEMS-1:0] vec_i,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o,
  output logic               one_hot_o
);

  always_comb begin
    // NOTE: default before the loop so every path assigns idx_o and no latch is inferred.
    idx_o = '0;
    for (int i = N_ELEMS - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IDX_W'(i);
    end
  end

  assign any_o     = |vec_i;
  assign one_hot_o = any_o && ((vec_i & (vec_i - N_ELEMS'(1))) == '0);

endmodule

// File: rtl/scnn_act_compressor.sv
// Snapshots a dense accumulator plane (ReLU + 16-bit saturation applied) and streams its
// non-zero activations as ascending (value, index) pairs, one per cycle under full ready.
module scnn_act_compressor
  import scnn_act_compressor_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start_i,
  input  logic                           relu_en_i,
  input  logic [N_ELEMS-1:0][IN_W-1:0]   dense_in_i,
  scnn_act_compressor_if.master          out_if,
  output logic                           busy_o,
  output logic                           done_o,
  output logic [IDX_W:0]                 nnz_count_o
);

  cmp_state_t                     state_q;
  logic [N_ELEMS-1:0][OUT_W-1:0]  snap_q;
  logic [N_ELEMS-1:0]             mask_q;
  act_pair_t                      pair_q;
  logic                           valid_q;
  logic                           last_q;
  logic                           busy_q;
  logic                           done_q;
  logic [IDX_W:0]                 nnz_q;

  logic [N_ELEMS-1:0][OUT_W-1:0]  plane_d;
  logic [N_ELEMS-1:0]             mask_d;
  logic [N_ELEMS-1:0]             sel_vec;
  logic [N_ELEMS-1:0]             ffs_vec;
  logic [IDX_W-1:0]               ffs_idx;
  logic                           ffs_any;
  logic                           ffs_one_hot;
  logic                           fire;

  always_comb begin
    for (int i = 0; i < N_ELEMS; i++) begin
      plane_d[i] = sat_relu(dense_in_i[i], relu_en_i);
      mask_d[i]  = |plane_d[i];
    end
  end

  // In EMIT the search runs on the mask with the pair on the bus already removed,
  // so the next pair is ready at the same edge that accepts the current one.
  always_comb begin
    sel_vec                = '0;
    sel_vec[pair_q.index]  = 1'b1;
    ffs_vec                = (state_q == EMIT) ? (mask_q & ~sel_vec) : mask_q;
  end

  scnn_act_compressor_ffs u_ffs (
    .vec_i     (ffs_vec),
    .idx_o     (ffs_idx),
    .any_o     (ffs_any),
    .one_hot_o (ffs_one_hot)
  );

  assign fire = valid_q && out_if.ready;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      // NOTE: the snapshot is a register bank, not a RAM, so clearing it on reset is cheap and keeps outputs deterministic.
      snap_q  <= '0;
      mask_q  <= '0;
      pair_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      nnz_q   <= '0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            snap_q  <= plane_d;
            mask_q  <= mask_d;
            nnz_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (!ffs_any) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            pair_q  <= '{value: snap_q[ffs_idx], index: ffs_idx};
            last_q  <= ffs_one_hot;
            valid_q <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (fire) begin
            mask_q <= ffs_vec;
            nnz_q  <= nnz_q + (IDX_W + 1)'(1);
            if (ffs_any) begin
              pair_q <= '{value: snap_q[ffs_idx], index: ffs_idx};
              last_q <= ffs_one_hot;
            end else begin
              valid_q <= 1'b0;
              last_q  <= 1'b0;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.pair  = pair_q;
  assign out_if.last  = last_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;
  assign nnz_count_o  = nnz_q;

endmodule
